// File: rtl/dual_port_ram_core.sv
// Dual-port RAM with one write port and one registered read port on a shared clock.
// Per-location written flags mark locations never written since reset, and feed a
// saturating count of distinct locations written.
module dual_port_ram_core #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] wr_address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read,
    input  logic [ADDR_WIDTH-1:0] rd_address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid,
    output logic                  rd_uninit,
    output logic [ADDR_WIDTH:0]   wr_count
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]      wflag;
    logic                  collision;

    assign collision = write && read && (wr_address == rd_address);

    // The array itself has no reset; a write sampled while reset is high is dropped.
    always_ff @(posedge clock) begin
        if (write && !reset) begin
            mem[wr_address] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wflag    <= '0;
            wr_count <= '0;
        end else if (write) begin
            wflag[wr_address] <= 1'b1;
            if (!wflag[wr_address] && (wr_count != FULL_COUNT)) begin
                wr_count <= wr_count + (ADDR_WIDTH + 1)'(1);
            end
        end
    end

    // Write-first on collision; unwritten locations read as zero, not stale contents.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out  <= '0;
            rd_valid  <= 1'b0;
            rd_uninit <= 1'b0;
        end else if (read) begin
            rd_valid <= 1'b1;
            if (collision) begin
                data_out  <= data_in;
                rd_uninit <= 1'b0;
            end else if (wflag[rd_address]) begin
                data_out  <= mem[rd_address];
                rd_uninit <= 1'b0;
            end else begin
                data_out  <= '0;
                rd_uninit <= 1'b1;
            end
        end else begin
            rd_valid  <= 1'b0;
            rd_uninit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dual_port_ram_core.sv
// Self-checking bench for dual_port_ram_core: a vector table for the directed cases,
// a behavioural memory model feeding a read scoreboard, and hand-written reset sequences.
`timescale 1ns/1ps
module tb_dual_port_ram_core;

    localparam int DW    = 64;
    localparam int AW    = 12;
    localparam int DEPTH = 2 ** AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          write = 1'b0;
    logic [AW-1:0] wr_address = '0;
    logic [DW-1:0] data_in = '0;
    logic          read = 1'b0;
    logic [AW-1:0] rd_address = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid;
    logic          rd_uninit;
    logic [AW:0]   wr_count;

    dual_port_ram_core #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .write(write), .wr_address(wr_address),
        .data_in(data_in), .read(read), .rd_address(rd_address),
        .data_out(data_out), .rd_valid(rd_valid), .rd_uninit(rd_uninit),
        .wr_count(wr_count)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct packed {
        logic [DW:0] payload;
    } exp_t;

    logic [DW-1:0] model_mem  [DEPTH];
    logic          model_flag [DEPTH];
    int            model_count;
    logic [DW-1:0] model_last;
    logic [DW:0]   sb_queue [$];
    logic          last_read;
    int            checks   = 0;
    int            failures = 0;
    int            valid_run;

    task automatic check(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model_flag[i] = 1'b0;
        model_count = 0;
        model_last  = '0;
        sb_queue.delete();
    endtask

    task automatic doReset();
        write = 1'b0;
        read  = 1'b0;
        reset = 1'b1;
        #3;
        check("reset_rd_valid", DW'(rd_valid), '0);
        check("reset_rd_uninit", DW'(rd_uninit), '0);
        check("reset_data_out", data_out, '0);
        check("reset_wr_count", DW'(wr_count), '0);
        clearModel();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic checkOutput();
        logic [DW:0] exp_entry;
        if (last_read) begin
            if (sb_queue.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL scoreboard_empty: read result with no expectation queued");
            end else begin
                exp_entry = sb_queue.pop_front();
                check("rd_valid", DW'(rd_valid), DW'(1));
                check("rd_data", data_out, exp_entry[DW-1:0]);
                check("rd_uninit", DW'(rd_uninit), DW'(exp_entry[DW]));
            end
        end else begin
            check("idle_rd_valid", DW'(rd_valid), '0);
            check("idle_rd_uninit", DW'(rd_uninit), '0);
            check("hold_data_out", data_out, model_last);
        end
        check("wr_count", DW'(wr_count), DW'(model_count));
    endtask

    task automatic applyStimulus(input logic wr, input logic [AW-1:0] wa, input logic [DW-1:0] din,
                                 input logic rd, input logic [AW-1:0] ra);
        logic [DW-1:0] exp_data;
        logic          exp_un;
        write = wr; wr_address = wa; data_in = din;
        read  = rd; rd_address = ra;
        if (rd) begin
            if (wr && wa == ra) begin
                exp_data = din; exp_un = 1'b0;
            end else if (model_flag[ra]) begin
                exp_data = model_mem[ra]; exp_un = 1'b0;
            end else begin
                exp_data = '0; exp_un = 1'b1;
            end
            sb_queue.push_back({exp_un, exp_data});
            model_last = exp_data;
        end
        if (wr) begin
            if (!model_flag[wa] && model_count < DEPTH) model_count++;
            model_flag[wa] = 1'b1;
            model_mem[wa]  = din;
        end
        last_read = rd;
        @(posedge clock);
        #1;
        checkOutput();
        write = 1'b0;
        read  = 1'b0;
    endtask

    typedef struct {
        logic          wr;
        logic [AW-1:0] wa;
        logic [DW-1:0] din;
        logic          rd;
        logic [AW-1:0] ra;
        logic [DW-1:0] exp_data;
        logic          exp_uninit;
        int            exp_count;
    } vec_t;

    vec_t vecs [12];

    initial begin
        vecs[0]  = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h000, 64'h0,                  1'b1, 0};
        vecs[1]  = '{1'b1, 12'h0A5, 64'hDEADBEEF01234567,   1'b0, 12'h000, 64'h0,                  1'b0, 1};
        vecs[2]  = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h0A5, 64'hDEADBEEF01234567,   1'b0, 1};
        vecs[3]  = '{1'b1, 12'h3FF, 64'h1111,               1'b1, 12'h3FF, 64'h1111,               1'b0, 2};
        vecs[4]  = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h3FF, 64'h1111,               1'b0, 2};
        vecs[5]  = '{1'b1, 12'h010, 64'hAA,                 1'b0, 12'h000, 64'h0,                  1'b0, 3};
        vecs[6]  = '{1'b1, 12'h010, 64'hAA,                 1'b0, 12'h000, 64'h0,                  1'b0, 3};
        vecs[7]  = '{1'b1, 12'h010, 64'hBB,                 1'b0, 12'h000, 64'h0,                  1'b0, 3};
        vecs[8]  = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h010, 64'hBB,                 1'b0, 3};
        vecs[9]  = '{1'b1, 12'h020, 64'h55,                 1'b1, 12'h0A5, 64'hDEADBEEF01234567,   1'b0, 4};
        vecs[10] = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h020, 64'h55,                 1'b0, 4};
        vecs[11] = '{1'b0, 12'h000, 64'h0,                  1'b1, 12'h030, 64'h0,                  1'b1, 4};

        last_read = 1'b0;
        clearModel();
        @(negedge clock);
        doReset();

        // Directed vectors with hand-derived expectations
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].wr, vecs[i].wa, vecs[i].din, vecs[i].rd, vecs[i].ra);
            if (vecs[i].rd) begin
                check($sformatf("vec%0d_data", i), data_out, vecs[i].exp_data);
                check($sformatf("vec%0d_uninit", i), DW'(rd_uninit), DW'(vecs[i].exp_uninit));
            end
            check($sformatf("vec%0d_count", i), DW'(wr_count), DW'(vecs[i].exp_count));
        end

        // Fill every location with its address, then read back to back
        doReset();
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, AW'(a), DW'(a), 1'b0, '0);
        check("full_wr_count", DW'(wr_count), DW'(DEPTH));
        valid_run = 0;
        for (int a = 0; a < DEPTH; a++) begin
            applyStimulus(1'b0, '0, '0, 1'b1, AW'(a));
            if (rd_valid && data_out == DW'(a)) valid_run++;
        end
        check("b2b_valid_run", DW'(valid_run), DW'(DEPTH));
        applyStimulus(1'b1, 12'h123, 64'hCAFE, 1'b0, '0);
        check("saturated_wr_count", DW'(wr_count), DW'(DEPTH));

        // Reset asserted mid-burst with a read pending
        doReset();
        for (int a = 0; a < 10; a++) applyStimulus(1'b1, AW'(a), DW'(a + 100), 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h003);
        check("pre_reset_data", data_out, 64'd103);
        write = 1'b1; wr_address = 12'h00A; data_in = 64'hFFFF;
        read  = 1'b1; rd_address = 12'h004;
        #2;
        reset = 1'b1;
        #1;
        check("midburst_rd_valid", DW'(rd_valid), '0);
        check("midburst_wr_count", DW'(wr_count), '0);
        check("midburst_data_out", data_out, '0);
        @(posedge clock);
        #1;
        check("held_rd_valid", DW'(rd_valid), '0);
        check("held_wr_count", DW'(wr_count), '0);
        write = 1'b0;
        read  = 1'b0;
        clearModel();
        @(negedge clock);
        reset = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1, 12'h003);
        check("post_reset_data", data_out, '0);
        check("post_reset_uninit", DW'(rd_uninit), DW'(1));
        applyStimulus(1'b0, '0, '0, 1'b0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
